load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage directly downstream of the ALU: accepts the ALU result (effective address, or the LUI value) together with the opcode and store data, and performs LW/SW/LB/LBU/SB against the data memory through a variable-latency req/ack handshake. Non-memory results pass through with one register stage, so the block also acts as the EX/MEM boundary. It produces a single-cycle writeback pulse and result for the register-file write stage.

## Interface
- WIDTH, 32, datapath and address width (block is specified for 32)
- w_clock  in  1  clock, rising edge
- w_reset_n  in  1  asynchronous, active-low reset
- w_valid_in  in  1  ALU result valid this cycle
- w_mem_op  in  1  opcode is a load/store/LUI (same qualifier the ALU receives)
- w_op_code_6  in  6  opcode (LW, SW, LB, LBU, SB, LUI, or any other)
- w_addr_x  in  WIDTH  ALU output: effective address, or final value for non-memory ops and LUI
- w_store_data_x  in  WIDTH  rt value for SW/SB
- w_ready_out  out  1  block can accept an op this cycle
- w_dmem_req  out  1  memory request
- w_dmem_we  out  1  1 = write
- w_dmem_addr_x  out  WIDTH  word address ({addr[31:2], 2'b00})
- w_dmem_byte_en_4  out  4  byte lane enables
- w_dmem_wdata_x  out  WIDTH  write data
- w_dmem_ack  in  1  memory accepted/completed the request
- w_dmem_rdata_x  in  WIDTH  read data, valid in ack cycle
- w_valid_out  out  1  one-cycle result pulse
- w_wb_en  out  1  result must be written back (qualified by w_valid_out)
- w_result_x  out  WIDTH  writeback value
- w_misaligned  out  1  one-cycle pulse: LW/SW with addr[1:0] != 0

## Operation
- Accept when w_valid_in && w_ready_out. w_ready_out = (state != BUSY).
- States: IDLE, BUSY, DONE.
  - IDLE/DONE + accept of a memory op (LW/SW/LB/LBU/SB, w_mem_op=1, aligned) -> BUSY.
  - IDLE/DONE + accept of anything else (LUI, non-mem, misaligned) -> DONE.
  - BUSY + w_dmem_ack -> DONE; BUSY without ack stays BUSY.
  - DONE without accept -> IDLE.
- Passthrough (w_mem_op=0, or LUI): w_result_x = w_addr_x, w_wb_en = 1.
- LW: byte_en 4'b1111, result = rdata. LB/LBU: byte_en one-hot at addr[1:0] (little-endian, byte k = bits 8k+7:8k); result = selected byte sign-extended (LB) / zero-extended (LBU). LB at addr 2 reading 32'h12_80_34_56 -> 32'hFFFF_FF80.
- SW: byte_en 4'b1111, wdata = store data. SB: byte_en one-hot, wdata = store byte replicated in all four lanes. Stores: w_wb_en = 0.
- Misaligned LW/SW: no request; w_valid_out with w_wb_en = 0, w_result_x = 0, w_misaligned = 1. Byte ops never misaligned.
- Unknown opcode with w_mem_op=1: treated as passthrough.

## Timing
- Reset (async assert): state IDLE; w_dmem_req, w_dmem_we, w_valid_out, w_wb_en, w_misaligned = 0; w_dmem_addr_x, w_dmem_wdata_x, w_result_x = 0; w_dmem_byte_en_4 = 0; w_ready_out = 1. Reset mid-BUSY abandons the request; req drops immediately.
- Accept at edge T. Passthrough/misaligned: w_valid_out high for cycle T+1 only.
- Memory op: w_dmem_req and all dmem outputs registered, high/stable from T+1 until the ack cycle A inclusive (A >= T+1). Read data captured at edge ending A; w_valid_out high for cycle A+1.
- w_dmem_ack ignored when w_dmem_req = 0.
- Back-to-back: accept permitted in DONE, so a new op may be accepted in the same cycle w_valid_out is high; sustained throughput 1 op/cycle for passthrough, 1 op per (latency+1) for memory.
- Inputs are don't-care when w_valid_in = 0.

## Structure
- Opcode defines (LW, SW, LB, LBU, SB, LUI) come from the shared isa_codes.v; state encodings are local parameters.
- One combinational sub-module, load_align: (op, addr[1:0], rdata) -> extended load result, and (op, addr[1:0], store data) -> byte_en, wdata.

## Test plan
- LUI then ADDU passthrough, w_addr_x = 32'h1234_0000 then 32'h5 back-to-back -> w_valid_out at T+1 and T+2, results 32'h1234_0000, 32'h5, w_wb_en = 1, no w_dmem_req.
- LW addr 32'h100, ack after 3 cycles with rdata 32'hDEAD_BEEF -> req high 3 cycles, byte_en 4'hF, w_ready_out low throughout, result 32'hDEAD_BEEF one cycle after ack.
- LB/LBU addr 32'h102, rdata 32'h1280_3456 -> LB result 32'hFFFF_FF80, LBU 32'h0000_0080, byte_en 4'b0100.
- SB addr 32'h203, data 32'h0000_00A5, immediate ack -> dmem_addr 32'h200, byte_en 4'b1000, wdata 32'hA5A5_A5A5, we = 1, w_wb_en = 0.
- SW addr 32'h201 -> no req, w_misaligned and w_valid_out pulse one cycle, w_wb_en = 0.
- Reset asserted while BUSY, later spurious ack -> outputs at reset values immediately, ack ignored, next LW works normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared opcode encodings and FSM state type for the load/store unit.
// Opcode values match the shared ISA opcode table (MIPS-style I-type opcodes).
package load_store_unit_pkg;

    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } lsu_state_e;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: extends the selected load byte and builds store
// byte enables / replicated write data. Purely combinational.
module load_align #(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       ld_op,
    input  logic [1:0]       ld_lane,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] ld_result,
    input  logic [5:0]       st_op,
    input  logic [1:0]       st_lane,
    input  logic [WIDTH-1:0] st_data,
    output logic [3:0]       byte_en,
    output logic [WIDTH-1:0] wdata
);
    import load_store_unit_pkg::*;

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte = rdata[7:0];
        case (ld_lane)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase

        case (ld_op)
            OP_LB:   ld_result = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
            OP_LBU:  ld_result = {{(WIDTH-8){1'b0}}, sel_byte};
            default: ld_result = rdata;
        endcase
    end

    always_comb begin
        case (st_op)
            OP_LB, OP_LBU, OP_SB: byte_en = 4'b0001 << st_lane;
            default:              byte_en = 4'b1111;
        endcase

        case (st_op)
            OP_SB:   wdata = {(WIDTH/8){st_data[7:0]}};
            OP_SW:   wdata = st_data;
            default: wdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: passes ALU results through one register stage and
// runs LW/SW/LB/LBU/SB against data memory over a req/ack handshake.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             w_clock,
    input  logic             w_reset_n,
    input  logic             w_valid_in,
    input  logic             w_mem_op,
    input  logic [5:0]       w_op_code_6,
    input  logic [WIDTH-1:0] w_addr_x,
    input  logic [WIDTH-1:0] w_store_data_x,
    output logic             w_ready_out,
    output logic             w_dmem_req,
    output logic             w_dmem_we,
    output logic [WIDTH-1:0] w_dmem_addr_x,
    output logic [3:0]       w_dmem_byte_en_4,
    output logic [WIDTH-1:0] w_dmem_wdata_x,
    input  logic             w_dmem_ack,
    input  logic [WIDTH-1:0] w_dmem_rdata_x,
    output logic             w_valid_out,
    output logic             w_wb_en,
    output logic [WIDTH-1:0] w_result_x,
    output logic             w_misaligned
);
    import load_store_unit_pkg::*;

    lsu_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [3:0]       byte_en_q, byte_en_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [5:0]       op_q, op_d;
    logic [1:0]       lane_q, lane_d;
    logic             valid_out_q, valid_out_d;
    logic             wb_en_q, wb_en_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             misaligned_q, misaligned_d;

    logic             accept;
    logic             is_load, is_store, is_mem, is_misaligned;
    logic [WIDTH-1:0] ld_result;
    logic [3:0]       acc_byte_en;
    logic [WIDTH-1:0] acc_wdata;

    assign w_ready_out = (state_q != ST_BUSY);
    assign accept      = w_valid_in && w_ready_out;

    assign is_load       = is_load_op(w_op_code_6);
    assign is_store      = is_store_op(w_op_code_6);
    assign is_mem        = w_mem_op && (is_load || is_store);
    assign is_misaligned = is_mem && ((w_op_code_6 == OP_LW) || (w_op_code_6 == OP_SW))
                           && (w_addr_x[1:0] != 2'b00);

    // Load side works on the op captured at accept; store side on the incoming op.
    load_align #(.WIDTH(WIDTH)) u_align (
        .ld_op     (op_q),
        .ld_lane   (lane_q),
        .rdata     (w_dmem_rdata_x),
        .ld_result (ld_result),
        .st_op     (w_op_code_6),
        .st_lane   (w_addr_x[1:0]),
        .st_data   (w_store_data_x),
        .byte_en   (acc_byte_en),
        .wdata     (acc_wdata)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        byte_en_d    = byte_en_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        lane_d       = lane_q;
        result_d     = result_q;
        valid_out_d  = 1'b0;
        wb_en_d      = 1'b0;
        misaligned_d = 1'b0;

        case (state_q)
            ST_BUSY: begin
                if (w_dmem_ack) begin
                    state_d     = ST_DONE;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    valid_out_d = 1'b1;
                    wb_en_d     = !we_q;
                    result_d    = we_q ? '0 : ld_result;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (is_mem && !is_misaligned) begin
                        state_d   = ST_BUSY;
                        req_d     = 1'b1;
                        we_d      = is_store;
                        addr_d    = {w_addr_x[WIDTH-1:2], 2'b00};
                        byte_en_d = acc_byte_en;
                        wdata_d   = acc_wdata;
                        op_d      = w_op_code_6;
                        lane_d    = w_addr_x[1:0];
                    end else begin
                        state_d      = ST_DONE;
                        valid_out_d  = 1'b1;
                        misaligned_d = is_misaligned;
                        wb_en_d      = !is_misaligned;
                        result_d     = is_misaligned ? '0 : w_addr_x;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            byte_en_q    <= '0;
            wdata_q      <= '0;
            op_q         <= '0;
            lane_q       <= '0;
            valid_out_q  <= 1'b0;
            wb_en_q      <= 1'b0;
            result_q     <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            byte_en_q    <= byte_en_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            valid_out_q  <= valid_out_d;
            wb_en_q      <= wb_en_d;
            result_q     <= result_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign w_dmem_req       = req_q;
    assign w_dmem_we        = we_q;
    assign w_dmem_addr_x    = addr_q;
    assign w_dmem_byte_en_4 = byte_en_q;
    assign w_dmem_wdata_x   = wdata_q;
    assign w_valid_out      = valid_out_q;
    assign w_wb_en          = wb_en_q;
    assign w_result_x       = result_q;
    assign w_misaligned     = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: passthrough, loads, stores,
// misalignment and reset during an outstanding request.
module tb_load_store_unit;

    localparam logic [5:0] LUI  = 6'h0F;
    localparam logic [5:0] LB   = 6'h20;
    localparam logic [5:0] LW   = 6'h23;
    localparam logic [5:0] LBU  = 6'h24;
    localparam logic [5:0] SB   = 6'h28;
    localparam logic [5:0] SW   = 6'h2B;
    localparam logic [5:0] ADDU = 6'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, mem_op, ready_out;
    logic [5:0]  op_code;
    logic [31:0] addr, store_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_byte_en;
    logic        valid_out, wb_en, misaligned;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32)) dut (
        .w_clock          (clk),
        .w_reset_n        (rst_n),
        .w_valid_in       (valid_in),
        .w_mem_op         (mem_op),
        .w_op_code_6      (op_code),
        .w_addr_x         (addr),
        .w_store_data_x   (store_data),
        .w_ready_out      (ready_out),
        .w_dmem_req       (dmem_req),
        .w_dmem_we        (dmem_we),
        .w_dmem_addr_x    (dmem_addr),
        .w_dmem_byte_en_4 (dmem_byte_en),
        .w_dmem_wdata_x   (dmem_wdata),
        .w_dmem_ack       (dmem_ack),
        .w_dmem_rdata_x   (dmem_rdata),
        .w_valid_out      (valid_out),
        .w_wb_en          (wb_en),
        .w_result_x       (result),
        .w_misaligned     (misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge; returns at T+1 (+1ns).
    task automatic issue(input logic [5:0] op, input logic mem, input logic [31:0] a,
                         input logic [31:0] sd);
        valid_in   = 1'b1;
        mem_op     = mem;
        op_code    = op;
        addr       = a;
        store_data = sd;
        step();
        valid_in   = 1'b0;
    endtask

    // Hold req for lat cycles, ack on the last; returns at A+1 (+1ns).
    task automatic serve(input int lat, input logic [31:0] rd, input string tag);
        for (int i = 0; i < lat; i++) begin
            check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
            check({tag, "_ready_lo"}, {31'd0, ready_out}, 32'd0);
            check({tag, "_vout_lo"}, {31'd0, valid_out}, 32'd0);
            if (i == lat - 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd;
            end
            step();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hBAD0_BAD0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        mem_op     = 1'b0;
        op_code    = '0;
        addr       = '0;
        store_data = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        #1;
        check("rst_ready", {31'd0, ready_out}, 32'd1);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_vout", {31'd0, valid_out}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_be", {28'd0, dmem_byte_en}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // LUI then ADDU back-to-back
        issue(LUI, 1'b1, 32'h1234_0000, 32'd0);
        check("lui_vout", {31'd0, valid_out}, 32'd1);
        check("lui_result", result, 32'h1234_0000);
        check("lui_wb", {31'd0, wb_en}, 32'd1);
        check("lui_req", {31'd0, dmem_req}, 32'd0);
        check("lui_ready", {31'd0, ready_out}, 32'd1);
        issue(ADDU, 1'b0, 32'h0000_0005, 32'd0);
        check("addu_vout", {31'd0, valid_out}, 32'd1);
        check("addu_result", result, 32'h0000_0005);
        check("addu_wb", {31'd0, wb_en}, 32'd1);
        check("addu_req", {31'd0, dmem_req}, 32'd0);
        step();
        check("pass_vout_end", {31'd0, valid_out}, 32'd0);

        // LW, ack after 3 cycles
        issue(LW, 1'b1, 32'h0000_0100, 32'd0);
        check("lw_addr", dmem_addr, 32'h0000_0100);
        check("lw_be", {28'd0, dmem_byte_en}, 32'hF);
        check("lw_we", {31'd0, dmem_we}, 32'd0);
        serve(3, 32'hDEAD_BEEF, "lw");
        check("lw_vout", {31'd0, valid_out}, 32'd1);
        check("lw_result", result, 32'hDEAD_BEEF);
        check("lw_wb", {31'd0, wb_en}, 32'd1);
        check("lw_req_drop", {31'd0, dmem_req}, 32'd0);
        step();
        check("lw_vout_end", {31'd0, valid_out}, 32'd0);

        // LB / LBU at lane 2
        issue(LB, 1'b1, 32'h0000_0102, 32'd0);
        check("lb_addr", dmem_addr, 32'h0000_0100);
        check("lb_be", {28'd0, dmem_byte_en}, 32'b0100);
        serve(1, 32'h1280_3456, "lb");
        check("lb_result", result, 32'hFFFF_FF80);
        check("lb_wb", {31'd0, wb_en}, 32'd1);
        step();
        issue(LBU, 1'b1, 32'h0000_0102, 32'd0);
        check("lbu_be", {28'd0, dmem_byte_en}, 32'b0100);
        serve(2, 32'h1280_3456, "lbu");
        check("lbu_vout", {31'd0, valid_out}, 32'd1);
        check("lbu_result", result, 32'h0000_0080);

        // accept in DONE while the previous result pulse is out
        check("done_ready", {31'd0, ready_out}, 32'd1);
        issue(ADDU, 1'b0, 32'h0000_0077, 32'd0);
        check("b2b_vout", {31'd0, valid_out}, 32'd1);
        check("b2b_result", result, 32'h0000_0077);
        step();

        // LB lane 0, positive byte
        issue(LB, 1'b1, 32'h0000_0100, 32'd0);
        check("lb0_be", {28'd0, dmem_byte_en}, 32'b0001);
        serve(1, 32'h1234_567F, "lb0");
        check("lb0_result", result, 32'h0000_007F);
        step();

        // SB lane 3, immediate ack
        issue(SB, 1'b1, 32'h0000_0203, 32'h0000_00A5);
        check("sb_addr", dmem_addr, 32'h0000_0200);
        check("sb_be", {28'd0, dmem_byte_en}, 32'b1000);
        check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        check("sb_we", {31'd0, dmem_we}, 32'd1);
        serve(1, 32'd0, "sb");
        check("sb_vout", {31'd0, valid_out}, 32'd1);
        check("sb_wb", {31'd0, wb_en}, 32'd0);
        step();

        // aligned SW
        issue(SW, 1'b1, 32'h0000_0204, 32'hCAFE_1234);
        check("sw_addr", dmem_addr, 32'h0000_0204);
        check("sw_be", {28'd0, dmem_byte_en}, 32'hF);
        check("sw_wdata", dmem_wdata, 32'hCAFE_1234);
        check("sw_we", {31'd0, dmem_we}, 32'd1);
        serve(2, 32'd0, "sw");
        check("sw_wb", {31'd0, wb_en}, 32'd0);
        step();

        // misaligned SW
        issue(SW, 1'b1, 32'h0000_0201, 32'h1111_2222);
        check("mis_req", {31'd0, dmem_req}, 32'd0);
        check("mis_flag", {31'd0, misaligned}, 32'd1);
        check("mis_vout", {31'd0, valid_out}, 32'd1);
        check("mis_wb", {31'd0, wb_en}, 32'd0);
        check("mis_result", result, 32'd0);
        step();
        check("mis_flag_end", {31'd0, misaligned}, 32'd0);
        check("mis_vout_end", {31'd0, valid_out}, 32'd0);

        // unknown opcode with mem_op=1 passes through
        issue(6'h3A, 1'b1, 32'h0000_0ABC, 32'd0);
        check("unk_req", {31'd0, dmem_req}, 32'd0);
        check("unk_result", result, 32'h0000_0ABC);
        check("unk_wb", {31'd0, wb_en}, 32'd1);
        step();

        // reset while BUSY, then spurious ack
        issue(LW, 1'b1, 32'h0000_0300, 32'd0);
        check("rb_req", {31'd0, dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_req_drop", {31'd0, dmem_req}, 32'd0);
        check("rb_ready", {31'd0, ready_out}, 32'd1);
        check("rb_addr", dmem_addr, 32'd0);
        check("rb_be", {28'd0, dmem_byte_en}, 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_5555;
        step();
        rst_n = 1'b1;
        step();
        step();
        check("spur_vout", {31'd0, valid_out}, 32'd0);
        check("spur_req", {31'd0, dmem_req}, 32'd0);
        check("spur_result", result, 32'd0);
        dmem_ack = 1'b0;
        issue(LW, 1'b1, 32'h0000_0104, 32'd0);
        check("post_addr", dmem_addr, 32'h0000_0104);
        serve(2, 32'hCAFE_F00D, "post");
        check("post_vout", {31'd0, valid_out}, 32'd1);
        check("post_result", result, 32'hCAFE_F00D);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
